// File: rtl/conv3_dw_window_gen_if.sv
// Pixel-in / window-out bus between a raster pixel producer and conv3_dw.
// The slave modport is the window generator; master is whoever drives pixels.
interface conv3_dw_window_gen_if #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned ACT_W    = 16
);
  logic                        in_valid;
  logic [CHANNELS*ACT_W-1:0]   in_pixel;
  logic                        in_ready;
  logic                        out_valid;
  logic [CHANNELS*9*ACT_W-1:0] out_act;

  modport master (output in_valid, in_pixel, input in_ready, out_valid, out_act);
  modport slave  (input in_valid, in_pixel, output in_ready, out_valid, out_act);
endinterface

// File: rtl/conv3_dw_window_gen.sv
// Turns a raster pixel stream into zero-padded 3x3 windows (stride 1, same padding)
// packed in the flat per-channel tap layout conv3_dw expects.
module conv3_dw_window_gen #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned ACT_W    = 16,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  conv3_dw_window_gen_if.slave  bus
);
  localparam int unsigned PIX_W  = CHANNELS * ACT_W;
  localparam int unsigned WIN_W  = CHANNELS * 9 * ACT_W;
  localparam int unsigned SR_LEN = 2 * IMG_W + 3;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned P_W    = $clog2(NPIX);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIN_W-1:0]   out_act_q, out_act_d;
  logic [PIX_W-1:0]   sr_q [SR_LEN];
  logic [PIX_W-1:0]   sr_d [SR_LEN];
  logic               accept;
  logic               emit;

  assign accept        = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;

  // Frame sequencing; p counts accepted pixels, then reused to count flush cycles.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    emit    = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          p_d = p_q + P_W'(1);
          if (p_q == P_W'(IMG_W)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (p_q == P_W'(NPIX - 1)) begin
            state_d = ST_FLUSH;
            p_d     = '0;
          end else begin
            p_d = p_q + P_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        emit = 1'b1;
        if (p_q == P_W'(IMG_W)) begin
          state_d = ST_FILL;
          p_d     = '0;
        end else begin
          p_d = p_q + P_W'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase
    in_ready_d = (state_d != ST_FLUSH);
  end

  // Shift in the accepted pixel, or zero while flushing the tail of the frame.
  always_comb begin
    sr_d = sr_q;
    if (accept || state_q == ST_FLUSH) begin
      sr_d[0] = (state_q == ST_FLUSH) ? '0 : bus.in_pixel;
      for (int i = 1; i < int'(SR_LEN); i++) sr_d[i] = sr_q[i-1];
    end
  end

  // Tap selection from the post-shift SR; border masking hides stale and wrapped pixels.
  always_comb begin
    out_act_d   = out_act_q;
    out_valid_d = emit;
    col_d       = col_q;
    row_d       = row_q;
    if (emit) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            if ((ky == 0 && row_q == '0) || (ky == 2 && row_q == ROW_W'(IMG_H - 1)) ||
                (kx == 0 && col_q == '0) || (kx == 2 && col_q == COL_W'(IMG_W - 1))) begin
              out_act_d[(c*9 + ky*3 + kx)*int'(ACT_W) +: ACT_W] = '0;
            end else begin
              out_act_d[(c*9 + ky*3 + kx)*int'(ACT_W) +: ACT_W] =
                sr_d[(2 - ky)*int'(IMG_W) + 2 - kx][c*int'(ACT_W) +: ACT_W];
            end
          end
        end
      end
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FILL;
      p_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
    end
  end

  // Line storage needs no reset: masking never exposes pixels from before the frame.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end
endmodule

// File: tb/tb_conv3_dw_window_gen.sv
// Bench for conv3_dw_window_gen on a 4x4 image: spec tap table plus a padded-image
// reference model checked on every window, under steady, gapped and random input.
module tb_conv3_dw_window_gen;
  localparam int unsigned CH    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 4;
  localparam int unsigned NP    = W * H;
  localparam int unsigned PIX_W = CH * AW;
  localparam int unsigned WIN_W = CH * 9 * AW;

  typedef struct {
    int n;
    int c;
    int k;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv3_dw_window_gen_if #(.CHANNELS(CH), .ACT_W(AW)) bus ();

  conv3_dw_window_gen #(.CHANNELS(CH), .ACT_W(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int acc_cnt, flush_left, centre, low_cnt, win_cnt;
  bit frame_done, cap_en, cmp_saved;
  logic [WIN_W-1:0] saved [NP];
  vec_t tbl[$];

  function automatic logic [PIX_W-1:0] pix(input int p);
    logic [PIX_W-1:0] v;
    for (int c = 0; c < int'(CH); c++) v[c*AW +: AW] = AW'(p + 1 + 256*c);
    return v;
  endfunction

  // Window of the zero-padded image around centre n, taps row-major.
  function automatic logic [WIN_W-1:0] model_win(input int n);
    logic [WIN_W-1:0] w;
    int r, cc, val;
    for (int c = 0; c < int'(CH); c++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          r  = n / int'(W) + ky - 1;
          cc = n % int'(W) + kx - 1;
          val = (r >= 0 && r < int'(H) && cc >= 0 && cc < int'(W)) ? r*int'(W) + cc + 1 + 256*c : 0;
          w[(c*9 + ky*3 + kx)*AW +: AW] = AW'(val);
        end
    return w;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_win(input string name, input int n, input logic [WIN_W-1:0] got,
                           input logic [WIN_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 0; i < int'(CH)*9; i++)
        if (got[i*AW +: AW] !== exp[i*AW +: AW]) begin
          $display("FAIL %s centre %0d chan %0d tap %0d got %0d exp %0d", name, n, i/9, i%9,
                   got[i*AW +: AW], exp[i*AW +: AW]);
          break;
        end
    end
  endtask

  task automatic reset_model();
    acc_cnt    = 0;
    flush_left = 0;
    centre     = 0;
  endtask

  // One clock: drive, advance the frame model across the edge, check what the DUT shows.
  task automatic step(input bit want);
    bit acc, em;
    bus.in_valid = want;
    bus.in_pixel = pix(acc_cnt);
    acc = want && (flush_left == 0);
    @(posedge clk);
    #1;
    em = 1'b0;
    if (acc) begin
      em = (acc_cnt >= int'(W) + 1);
      acc_cnt++;
      if (acc_cnt == int'(NP)) begin
        acc_cnt    = 0;
        flush_left = W + 1;
      end
    end else if (flush_left > 0) begin
      em = 1'b1;
      flush_left--;
      if (flush_left == 0) frame_done = 1'b1;
    end
    check_int("out_valid", int'(bus.out_valid), int'(em));
    if (bus.out_valid) begin
      win_cnt++;
      check_win("window", centre, bus.out_act, model_win(centre));
      if (cap_en) saved[centre] = bus.out_act;
      if (cmp_saved) check_win("frame_repeat", centre, bus.out_act, saved[centre]);
      centre = (centre + 1) % int'(NP);
    end
    if (!bus.in_ready) low_cnt++;
    check_int("in_ready", int'(bus.in_ready), (flush_left == 0) ? 1 : 0);
  endtask

  // mode 0: valid held high, 1: alternating, 2: random bubbles.
  task automatic run_frame(input int mode);
    int guard;
    bit want;
    guard = 0; low_cnt = 0; win_cnt = 0; frame_done = 1'b0;
    while (!frame_done && guard < 400) begin
      case (mode)
        0:       want = 1'b1;
        1:       want = (guard % 2 == 0);
        default: want = ($urandom % 3 != 0);
      endcase
      step(want);
      guard++;
    end
    check_int("frame_done", int'(frame_done), 1);
    check_int("windows_per_frame", win_cnt, int'(NP));
    check_int("ready_low_cycles", low_cnt, int'(W) + 1);
  endtask

  task automatic add_taps(input int n, input int e[9]);
    for (int k = 0; k < 9; k++) tbl.push_back('{n: n, c: 0, k: k, exp: e[k]});
  endtask

  initial begin
    int e0[9], e5[9], e12[9], e15[9];
    logic [WIN_W-1:0] wv;
    e0  = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    e5  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    e12 = '{0, 9, 10, 0, 13, 14, 0, 0, 0};
    e15 = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    add_taps(0, e0);
    add_taps(5, e5);
    add_taps(12, e12);
    add_taps(15, e15);
    tbl.push_back('{n: 5, c: 15, k: 4, exp: 3846});
    tbl.push_back('{n: 0, c: 15, k: 8, exp: 3846});

    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    cap_en = 1'b0;
    cmp_saved = 1'b0;
    reset_model();
    #12;
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_out_act_zero", (bus.out_act == '0) ? 1 : 0, 1);
    check_int("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rstn = 1'b1;

    cap_en = 1'b1;
    run_frame(0);
    cap_en = 1'b0;
    foreach (tbl[i]) begin
      wv = saved[tbl[i].n];
      check_int($sformatf("tap_n%0d_c%0d_k%0d", tbl[i].n, tbl[i].c, tbl[i].k),
                int'(wv[(tbl[i].c*9 + tbl[i].k)*AW +: AW]), tbl[i].exp);
    end

    cmp_saved = 1'b1;
    run_frame(1);
    run_frame(0);
    run_frame(0);
    for (int f = 0; f < 3; f++) run_frame(2);

    // Mid-frame asynchronous reset after 7 accepts.
    for (int i = 0; i < 7; i++) step(1'b1);
    #2 rstn = 1'b0;
    #1;
    check_int("midrst_out_valid", int'(bus.out_valid), 0);
    check_int("midrst_out_act_zero", (bus.out_act == '0) ? 1 : 0, 1);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    reset_model();
    #1;
    check_int("midrst_in_ready", int'(bus.in_ready), 1);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
